alu_serial_unit: RTL and testbench



---
 rtl/alu_serial_unit_pkg.sv | 32 +++
 rtl/alu_serial_unit_alu.sv | 64 ++++++
 rtl/alu_serial_unit.sv | 137 +++++++++++++
 tb/tb_alu_serial_unit.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_serial_unit_pkg.sv
// Shared types for the ALU service unit: opcode encoding, FSM states and
// small helpers used by both the unit and its combinational ALU.
package alu_serial_unit_pkg;

    localparam int ALU_W   = 32;
    localparam int SHAMT_W = 5;

    // Encodings 4'hA..4'hF are unassigned and behave as "unrecognised".
    typedef enum logic [3:0] {
        ALU_ADD  = 4'h0,
        ALU_SUB  = 4'h1,
        ALU_AND  = 4'h2,
        ALU_OR   = 4'h3,
        ALU_XOR  = 4'h4,
        ALU_SLT  = 4'h5,
        ALU_SLTU = 4'h6,
        ALU_SLL  = 4'h7,
        ALU_SRL  = 4'h8,
        ALU_SRA  = 4'h9
    } alu_control_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } alu_serial_state_t;

    function automatic logic is_shift(input alu_control_t control);
        return (control == ALU_SLL) || (control == ALU_SRL) || (control == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_serial_unit_alu.sv
// Combinational ALU for every non-shift operation; shift encodings return 0
// here because the serial unit produces those results itself.
module alu
    import alu_serial_unit_pkg::*;
#(
    parameter int N = 32
) (
    input  alu_control_t   control,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic [N-1:0]   result,
    output logic           overflow,
    output logic           zero,
    output logic           equal
);

    logic signed [N-1:0] a_s;
    logic signed [N-1:0] b_s;
    logic [N-1:0]        sum;
    logic [N-1:0]        diff;

    // Two's-complement overflow: operands agree in sign (ADD) or differ (SUB)
    // and the result sign departs from a.
    function automatic logic signed_overflow(
        input logic a_msb,
        input logic b_msb,
        input logic r_msb,
        input logic is_sub
    );
        logic same_sign;
        same_sign = (a_msb == b_msb);
        return (is_sub ? !same_sign : same_sign) && (r_msb != a_msb);
    endfunction

    assign a_s  = a;
    assign b_s  = b;
    assign sum  = a + b;
    assign diff = a - b;

    always_comb begin
        result   = '0;
        overflow = 1'b0;
        case (control)
            ALU_ADD: begin
                result   = sum;
                overflow = signed_overflow(a[N-1], b[N-1], sum[N-1], 1'b0);
            end
            ALU_SUB: begin
                result   = diff;
                overflow = signed_overflow(a[N-1], b[N-1], diff[N-1], 1'b1);
            end
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_SLT:  result = {{(N-1){1'b0}}, (a_s < b_s)};
            ALU_SLTU: result = {{(N-1){1'b0}}, (a < b)};
            default:  result = '0;
        endcase
    end

    assign zero  = (result == '0);
    assign equal = (a == b);

endmodule

// File: rtl/alu_serial_unit.sv
// Request/response ALU service: non-shift ops finish in one cycle through
// the combinational alu, shifts run one bit position per cycle.
module alu_serial_unit
    import alu_serial_unit_pkg::*;
#(
    parameter int N = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req_valid,
    output logic           req_ready,
    input  alu_control_t   req_control,
    input  logic [N-1:0]   req_a,
    input  logic [N-1:0]   req_b,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [N-1:0]   rsp_result,
    output logic           rsp_overflow,
    output logic           rsp_zero,
    output logic           rsp_equal,
    output logic           busy
);

    alu_serial_state_t     state;
    alu_serial_state_t     state_next;
    alu_control_t          ctl_q;
    logic [SHAMT_W-1:0]    cnt_q;
    logic [N-1:0]          a_q;
    logic [N-1:0]          b_q;
    logic [N-1:0]          sh_q;
    logic                  accept;

    logic [N-1:0]          alu_result;
    logic                  alu_overflow;
    logic                  alu_zero;
    logic                  alu_equal;

    function automatic logic [N-1:0] shift_step(
        input alu_control_t control,
        input logic [N-1:0] value
    );
        case (control)
            ALU_SLL: return {value[N-2:0], 1'b0};
            ALU_SRL: return {1'b0, value[N-1:1]};
            ALU_SRA: return {value[N-1], value[N-1:1]};
            default: return value;
        endcase
    endfunction

    alu #(.N(N)) u_alu (
        .control  (ctl_q),
        .a        (a_q),
        .b        (b_q),
        .result   (alu_result),
        .overflow (alu_overflow),
        .zero     (alu_zero),
        .equal    (alu_equal)
    );

    assign accept    = req_valid && (state == S_IDLE);
    assign req_ready = (state == S_IDLE);
    assign rsp_valid = (state == S_DONE);
    assign busy      = (state != S_IDLE);

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    if (is_shift(req_control) && (req_b[SHAMT_W-1:0] != '0))
                        state_next = S_SHIFT;
                    else
                        state_next = S_DONE;
                end
            end
            S_SHIFT: begin
                if (cnt_q == SHAMT_W'(1))
                    state_next = S_DONE;
            end
            S_DONE: begin
                if (rsp_ready)
                    state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Control state: FSM, captured opcode and remaining shift count.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            ctl_q <= ALU_ADD;
            cnt_q <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                ctl_q <= req_control;
                cnt_q <= req_b[SHAMT_W-1:0];
            end else if (state == S_SHIFT) begin
                cnt_q <= cnt_q - SHAMT_W'(1);
            end
        end
    end

    // Operand and shift datapath; only observed through S_DONE-gated outputs.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q  <= req_a;
            b_q  <= req_b;
            sh_q <= req_a;
        end else if (state == S_SHIFT) begin
            sh_q <= shift_step(ctl_q, sh_q);
        end
    end

    // Outputs are a pure function of registers, so they cannot move while
    // the unit waits in S_DONE, and they read as zero in every other state.
    always_comb begin
        rsp_result   = '0;
        rsp_overflow = 1'b0;
        rsp_zero     = 1'b0;
        rsp_equal    = 1'b0;
        if (state == S_DONE) begin
            if (is_shift(ctl_q)) begin
                rsp_result = sh_q;
                rsp_zero   = (sh_q == '0);
                rsp_equal  = (a_q == b_q);
            end else begin
                rsp_result   = alu_result;
                rsp_overflow = alu_overflow;
                rsp_zero     = alu_zero;
                rsp_equal    = alu_equal;
            end
        end
    end

endmodule

// File: tb/tb_alu_serial_unit.sv
// Scoreboard bench for alu_serial_unit: directed vectors with hand values,
// then random traffic against a behavioural model with random response stalls.
module tb_alu_serial_unit;
    import alu_serial_unit_pkg::*;

    localparam int N = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    alu_control_t  req_control;
    logic [N-1:0]  req_a;
    logic [N-1:0]  req_b;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [N-1:0]  rsp_result;
    logic          rsp_overflow;
    logic          rsp_zero;
    logic          rsp_equal;
    logic          busy;

    typedef struct {
        logic [N-1:0] result;
        logic         ovf;
        logic         zero;
        logic         equal;
        int           due;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   rdy_mode = 0;

    alu_serial_unit #(.N(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_control  (req_control),
        .req_a        (req_a),
        .req_b        (req_b),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_overflow (rsp_overflow),
        .rsp_zero     (rsp_zero),
        .rsp_equal    (rsp_equal),
        .busy         (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #900000;
        $display("FAIL watchdog cycle=%0d required=finished", cyc);
        $fatal(1, "watchdog expired");
    end

    // rsp_ready changes just after the rising edge so every sampler sees it stable.
    initial begin
        rsp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0:       rsp_ready = 1'b1;
                1:       rsp_ready = ($urandom_range(0, 2) != 0);
                default: rsp_ready = 1'b0;
            endcase
        end
    end

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic exp_t alu_behavioural(alu_control_t c, logic [N-1:0] a, logic [N-1:0] b);
        exp_t       e;
        logic [N-1:0] r;
        logic       v;
        logic [4:0] sh;
        r  = '0;
        v  = 1'b0;
        sh = b[4:0];
        case (c)
            ALU_ADD: begin r = a + b; v = (a[31] == b[31]) && (r[31] != a[31]); end
            ALU_SUB: begin r = a - b; v = (a[31] != b[31]) && (r[31] != a[31]); end
            ALU_AND:  r = a & b;
            ALU_OR:   r = a | b;
            ALU_XOR:  r = a ^ b;
            ALU_SLT:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_SLTU: r = (a < b) ? 32'd1 : 32'd0;
            ALU_SLL:  r = a << sh;
            ALU_SRL:  r = a >> sh;
            ALU_SRA:  r = $signed(a) >>> sh;
            default:  r = '0;
        endcase
        e.result = r;
        e.ovf    = v;
        e.zero   = (r == '0);
        e.equal  = (a == b);
        e.due    = 0;
        return e;
    endfunction

    // Monitor: pops one expectation per response and checks it on every valid cycle.
    initial begin
        exp_t cur;
        bit   have;
        have = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (rsp_valid) begin
                if (!have) begin
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_rsp actual=%h required=no response (cycle %0d)", rsp_result, cyc);
                    end else begin
                        cur  = sb.pop_front();
                        have = 1'b1;
                        chk("latency", 32'(cyc), 32'(cur.due));
                    end
                end
                if (have) begin
                    chk("rsp_result", rsp_result, cur.result);
                    chk("rsp_overflow", 32'(rsp_overflow), 32'(cur.ovf));
                    chk("rsp_zero", 32'(rsp_zero), 32'(cur.zero));
                    chk("rsp_equal", 32'(rsp_equal), 32'(cur.equal));
                end
                if (rsp_ready) have = 1'b0;
            end
        end
    end

    // Issues one request; returns the cycle number following the accepting edge.
    task automatic send(input alu_control_t c, input logic [N-1:0] a, input logic [N-1:0] b,
                        input bit expect_rsp, input exp_t e, output int acc);
        int w;
        int lat;
        @(negedge clk);
        req_control = c;
        req_a       = a;
        req_b       = b;
        req_valid   = 1'b1;
        w = 0;
        while (!req_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!req_ready) begin
            total++;
            bad++;
            $display("FAIL req_timeout actual=req_ready 0 required=1 (cycle %0d)", cyc);
            req_valid = 1'b0;
            acc = -1;
            return;
        end
        acc = cyc + 1;
        lat = ((c == ALU_SLL) || (c == ALU_SRL) || (c == ALU_SRA)) ? int'(b[4:0]) : 0;
        if (expect_rsp) begin
            e.due = acc + lat;
            sb.push_back(e);
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic send_hand(input alu_control_t c, input logic [N-1:0] a, input logic [N-1:0] b,
                             input logic [N-1:0] r, input logic v, input logic z, input logic q,
                             output int acc);
        exp_t e;
        e.result = r;
        e.ovf    = v;
        e.zero   = z;
        e.equal  = q;
        e.due    = 0;
        send(c, a, b, 1'b1, e, acc);
    endtask

    task automatic drain(input string name);
        int w;
        w = 0;
        while ((sb.size() != 0 || !req_ready) && w < 400) begin
            @(negedge clk);
            w++;
        end
        chk(name, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int   acc;
        exp_t e;
        bit   seen;
        logic [3:0] code;
        alu_control_t c;
        logic [N-1:0] a;
        logic [N-1:0] b;

        rst = 1'b1;
        req_valid = 1'b0;
        req_control = ALU_ADD;
        req_a = '0;
        req_b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_req_ready", 32'(req_ready), 32'd1);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_result", rsp_result, 32'h0);
        chk("reset_flags", {29'd0, rsp_overflow, rsp_zero, rsp_equal}, 32'd0);
        rst = 1'b0;

        // ADD overflow, single-cycle latency, req_ready back one cycle later.
        send_hand(ALU_ADD, 32'h7fffffff, 32'h00000001, 32'h80000000, 1'b1, 1'b0, 1'b0, acc);
        chk("add_rsp_valid", 32'(rsp_valid), 32'd1);
        @(negedge clk);
        chk("add_req_ready_back", 32'(req_ready), 32'd1);
        chk("add_busy_clear", 32'(busy), 32'd0);

        // SRA by 4: busy for four cycles before the response.
        send_hand(ALU_SRA, 32'h80000000, 32'h00000004, 32'hf8000000, 1'b0, 1'b0, 1'b0, acc);
        for (int i = 0; i < 4; i++) begin
            chk("sra_busy", 32'(busy), 32'd1);
            chk("sra_no_rsp_yet", 32'(rsp_valid), 32'd0);
            @(negedge clk);
        end
        drain("sra_drain");
        send_hand(ALU_SRL, 32'h80000000, 32'h00000004, 32'h08000000, 1'b0, 1'b0, 1'b0, acc);
        drain("srl_drain");
        send_hand(ALU_SLL, 32'h00000001, 32'h0000001f, 32'h80000000, 1'b0, 1'b0, 1'b0, acc);
        drain("sll31_drain");
        send_hand(ALU_SLL, 32'h00000001, 32'h00000020, 32'h00000001, 1'b0, 1'b0, 1'b0, acc);
        drain("sll0_drain");
        send_hand(ALU_SLTU, 32'h00000001, 32'hffffffff, 32'h00000001, 1'b0, 1'b0, 1'b0, acc);
        send_hand(ALU_SLT, 32'h00000001, 32'hffffffff, 32'h00000000, 1'b0, 1'b1, 1'b0, acc);
        send_hand(ALU_SUB, 32'h80000000, 32'h00000001, 32'h7fffffff, 1'b1, 1'b0, 1'b0, acc);
        send_hand(alu_control_t'(4'hE), 32'h00000005, 32'h00000005, 32'h0, 1'b0, 1'b1, 1'b1, acc);
        drain("misc_drain");

        // SUB with a three-cycle response stall; request pulses must be ignored.
        rdy_mode = 2;
        @(negedge clk);
        send_hand(ALU_SUB, 32'h12345678, 32'h12345678, 32'h0, 1'b0, 1'b1, 1'b1, acc);
        req_control = ALU_ADD;
        req_a = 32'h1;
        req_b = 32'h1;
        for (int i = 0; i < 3; i++) begin
            req_valid = 1'b1;
            chk("stall_req_ready", 32'(req_ready), 32'd0);
            chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
            if (i < 2) @(negedge clk);
        end
        req_valid = 1'b0;
        rdy_mode = 0;
        repeat (2) @(negedge clk);
        chk("stall_back_idle", 32'(req_ready), 32'd1);
        drain("stall_drain");

        // Reset in the middle of an SRL by 10: no response may appear.
        e = alu_behavioural(ALU_SRL, 32'hffff0000, 32'h0000000a);
        send(ALU_SRL, 32'hffff0000, 32'h0000000a, 1'b0, e, acc);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_req_ready", 32'(req_ready), 32'd1);
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_result", rsp_result, 32'h0);
        chk("midrst_flags", {29'd0, rsp_overflow, rsp_zero, rsp_equal}, 32'd0);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        chk("midrst_no_rsp", 32'(seen), 32'd0);
        send_hand(ALU_ADD, 32'h2, 32'h3, 32'h5, 1'b0, 1'b0, 1'b0, acc);
        drain("post_rst_drain");

        // Random traffic against the behavioural model with response stalls.
        rdy_mode = 1;
        for (int i = 0; i < 500; i++) begin
            code = 4'($urandom_range(0, 11));
            c = alu_control_t'(code);
            a = $urandom;
            b = ($urandom_range(0, 7) == 0) ? a : $urandom;
            if (($urandom_range(0, 5) == 0) && (c == ALU_ADD || c == ALU_SUB))
                a = {1'b0, 31'h7ffffff0} ^ {a[31], 31'h0};
            e = alu_behavioural(c, a, b);
            send(c, a, b, 1'b1, e, acc);
        end
        rdy_mode = 0;
        drain("random_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
